// File: rtl/rotation_nco_ctrl.sv
// rotation_nco_ctrl
// Run-lifecycle sequencer and NCO phase generator for the I/Q rotator.
// Incoming I/Q samples are delayed two stages so that they arrive at the
// rotator together with the sine/cosine derived from the phase accumulator.
// The sine/cosine values come from a quarter-wave table.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | configuration accepted, waiting for start
// RUN   | samples accepted, accumulator advances once per accepted sample
// DRAIN | three cycles to flush the pipeline and rotator register, then IDLE
module rotation_nco_ctrl #(
  parameter int NB_OUTPUT  = 8,
  parameter int NBF_OUTPUT = 6,
  parameter int NB_PHASE   = 16
) (
  input  logic                 clock,
  input  logic                 i_reset,
  input  logic                 i_cfg_valid,
  input  logic [NB_PHASE-1:0]  i_cfg_freq,
  input  logic [NB_PHASE-1:0]  i_cfg_phase,
  output logic                 o_cfg_ready,
  input  logic                 i_start,
  input  logic                 i_stop,
  input  logic                 i_valid,
  input  logic [NB_OUTPUT-1:0] i_dataI,
  input  logic [NB_OUTPUT-1:0] i_dataQ,
  output logic                 o_ready,
  output logic [NB_OUTPUT-1:0] o_dataI,
  output logic [NB_OUTPUT-1:0] o_dataQ,
  output logic [NB_OUTPUT-1:0] o_dataSin,
  output logic [NB_OUTPUT-1:0] o_dataCos,
  output logic                 o_valid,
  output logic                 o_rot_valid,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam int NB_ADDR = 6;
  localparam logic [NB_OUTPUT-1:0] UNITY = NB_OUTPUT'(1 << NBF_OUTPUT);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [1:0]          drain_cnt;
  logic                done_reg;
  logic [NB_PHASE-1:0] acc;
  logic [NB_PHASE-1:0] freq_reg;

  logic                sample_acc;
  logic                cfg_acc;
  logic                drain_last;

  logic                s1_valid;
  logic [NB_OUTPUT-1:0] s1_i;
  logic [NB_OUTPUT-1:0] s1_q;
  logic [NB_ADDR-1:0]  s1_addr;

  logic [1:0]          lut_qd;
  logic [4:0]          lut_k;
  logic [NB_OUTPUT-1:0] q_k;
  logic [NB_OUTPUT-1:0] q_kc;
  logic [NB_OUTPUT-1:0] lut_sin;
  logic [NB_OUTPUT-1:0] lut_cos;

  logic                s2_valid;
  logic [NB_OUTPUT-1:0] s2_i;
  logic [NB_OUTPUT-1:0] s2_q;
  logic [NB_OUTPUT-1:0] s2_sin;
  logic [NB_OUTPUT-1:0] s2_cos;
  logic                rot_valid;

  // Quarter-wave sine table, 17 points covering 0..pi/2 inclusive.
  function automatic logic [NB_OUTPUT-1:0] quarter(input logic [4:0] idx);
    logic [NB_OUTPUT-1:0] v;
    case (idx)
      5'd0:    v = NB_OUTPUT'(0);
      5'd1:    v = NB_OUTPUT'(6);
      5'd2:    v = NB_OUTPUT'(12);
      5'd3:    v = NB_OUTPUT'(19);
      5'd4:    v = NB_OUTPUT'(24);
      5'd5:    v = NB_OUTPUT'(30);
      5'd6:    v = NB_OUTPUT'(36);
      5'd7:    v = NB_OUTPUT'(41);
      5'd8:    v = NB_OUTPUT'(45);
      5'd9:    v = NB_OUTPUT'(49);
      5'd10:   v = NB_OUTPUT'(53);
      5'd11:   v = NB_OUTPUT'(56);
      5'd12:   v = NB_OUTPUT'(59);
      5'd13:   v = NB_OUTPUT'(61);
      5'd14:   v = NB_OUTPUT'(63);
      default: v = UNITY;
    endcase
    return v;
  endfunction

  assign sample_acc = i_valid & (state == ST_RUN);
  assign cfg_acc    = i_cfg_valid & (state == ST_IDLE);
  assign drain_last = (state == ST_DRAIN) && (drain_cnt == 2'd0);

  // State register.
  always_ff @(posedge clock) begin
    if (i_reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode; start/stop are only honoured in their own state.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (i_start)   state_next = ST_RUN;
      ST_RUN:   if (i_stop)    state_next = ST_DRAIN;
      ST_DRAIN: if (drain_last) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Drain down-counter: loaded on stop, terminal count ends the drain.
  always_ff @(posedge clock) begin
    if (i_reset) begin
      drain_cnt <= 2'd0;
    end else if ((state == ST_RUN) && i_stop) begin
      drain_cnt <= 2'd2;
    end else if ((state == ST_DRAIN) && (drain_cnt != 2'd0)) begin
      drain_cnt <= drain_cnt - 2'd1;
    end
  end

  // Done pulse coincides with the first IDLE cycle after a drain.
  always_ff @(posedge clock) begin
    if (i_reset) begin
      done_reg <= 1'b0;
    end else begin
      done_reg <= drain_last;
    end
  end

  // Phase accumulator and frequency word; wraps silently modulo a full turn.
  always_ff @(posedge clock) begin
    if (i_reset) begin
      acc      <= '0;
      freq_reg <= '0;
    end else if (cfg_acc) begin
      acc      <= i_cfg_phase;
      freq_reg <= i_cfg_freq;
    end else if (sample_acc) begin
      acc      <= acc + freq_reg;
    end
  end

  // Stage 1: capture sample and truncated table address of the current phase.
  always_ff @(posedge clock) begin
    if (i_reset) begin
      s1_valid <= 1'b0;
      s1_i     <= '0;
      s1_q     <= '0;
      s1_addr  <= '0;
    end else begin
      s1_valid <= sample_acc;
      if (sample_acc) begin
        s1_i    <= i_dataI;
        s1_q    <= i_dataQ;
        s1_addr <= acc[NB_PHASE-1 -: NB_ADDR];
      end
    end
  end

  assign lut_qd = s1_addr[5:4];
  assign lut_k  = {1'b0, s1_addr[3:0]};
  assign q_k    = quarter(lut_k);
  assign q_kc   = quarter(5'd16 - lut_k);

  // Quadrant folding of the quarter-wave table into full sin/cos.
  always_comb begin
    lut_sin = q_k;
    lut_cos = q_kc;
    case (lut_qd)
      2'd0: begin
        lut_sin = q_k;
        lut_cos = q_kc;
      end
      2'd1: begin
        lut_sin = q_kc;
        lut_cos = -q_k;
      end
      2'd2: begin
        lut_sin = -q_k;
        lut_cos = -q_kc;
      end
      default: begin
        lut_sin = -q_kc;
        lut_cos = q_k;
      end
    endcase
  end

  // Stage 2: rotator input registers; data holds while no sample is present.
  always_ff @(posedge clock) begin
    if (i_reset) begin
      s2_valid <= 1'b0;
      s2_i     <= '0;
      s2_q     <= '0;
      s2_sin   <= '0;
      s2_cos   <= '0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_i   <= s1_i;
        s2_q   <= s1_q;
        s2_sin <= lut_sin;
        s2_cos <= lut_cos;
      end
    end
  end

  // Tracks the rotator's own output register, one cycle behind its inputs.
  always_ff @(posedge clock) begin
    if (i_reset) begin
      rot_valid <= 1'b0;
    end else begin
      rot_valid <= s2_valid;
    end
  end

  assign o_cfg_ready = (state == ST_IDLE);
  assign o_ready     = (state == ST_RUN);
  assign o_busy      = (state != ST_IDLE);
  assign o_done      = done_reg;
  assign o_valid     = s2_valid;
  assign o_rot_valid = rot_valid;
  assign o_dataI     = s2_i;
  assign o_dataQ     = s2_q;
  assign o_dataSin   = s2_sin;
  assign o_dataCos   = s2_cos;

endmodule

// File: tb/tb_rotation_nco_ctrl.sv
// Bench for rotation_nco_ctrl: scripted and random stimulus replayed against
// a cycle-level reference that derives sin/cos from real trigonometry.
module tb_rotation_nco_ctrl;

  logic       clock = 1'b0;
  logic       i_reset = 1'b0;
  logic       i_cfg_valid = 1'b0;
  logic [15:0] i_cfg_freq = '0;
  logic [15:0] i_cfg_phase = '0;
  logic       o_cfg_ready;
  logic       i_start = 1'b0;
  logic       i_stop = 1'b0;
  logic       i_valid = 1'b0;
  logic [7:0] i_dataI = '0;
  logic [7:0] i_dataQ = '0;
  logic       o_ready;
  logic [7:0] o_dataI, o_dataQ, o_dataSin, o_dataCos;
  logic       o_valid, o_rot_valid, o_busy, o_done;

  int tests = 0;
  int failed = 0;

  rotation_nco_ctrl dut (
    .clock(clock), .i_reset(i_reset),
    .i_cfg_valid(i_cfg_valid), .i_cfg_freq(i_cfg_freq), .i_cfg_phase(i_cfg_phase),
    .o_cfg_ready(o_cfg_ready), .i_start(i_start), .i_stop(i_stop),
    .i_valid(i_valid), .i_dataI(i_dataI), .i_dataQ(i_dataQ), .o_ready(o_ready),
    .o_dataI(o_dataI), .o_dataQ(o_dataQ), .o_dataSin(o_dataSin), .o_dataCos(o_dataCos),
    .o_valid(o_valid), .o_rot_valid(o_rot_valid), .o_busy(o_busy), .o_done(o_done)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic rst, cfg_v;
    logic [15:0] freq, phase;
    logic start, stop, valid;
    logic [7:0] di, dq;
  } stim_t;

  typedef struct packed {
    logic valid, rot, busy, done, ready, cfg_ready;
    logic [7:0] di, dq, s, c;
  } obs_t;

  stim_t stim[$];
  obs_t  lg[$];
  obs_t  ex[$];

  task automatic add(input logic rst, input logic cfg_v, input logic [15:0] freq,
                     input logic [15:0] phase, input logic start, input logic stop,
                     input logic valid, input logic [7:0] di, input logic [7:0] dq);
    stim_t s;
    s.rst = rst; s.cfg_v = cfg_v; s.freq = freq; s.phase = phase;
    s.start = start; s.stop = stop; s.valid = valid; s.di = di; s.dq = dq;
    stim.push_back(s);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) add(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Apply the script one clock per entry and log outputs 1 time unit after each edge.
  task automatic run_stim();
    obs_t o;
    lg.delete();
    foreach (stim[n]) begin
      i_reset = stim[n].rst; i_cfg_valid = stim[n].cfg_v;
      i_cfg_freq = stim[n].freq; i_cfg_phase = stim[n].phase;
      i_start = stim[n].start; i_stop = stim[n].stop; i_valid = stim[n].valid;
      i_dataI = stim[n].di; i_dataQ = stim[n].dq;
      @(posedge clock);
      #1;
      o.valid = o_valid; o.rot = o_rot_valid; o.busy = o_busy; o.done = o_done;
      o.ready = o_ready; o.cfg_ready = o_cfg_ready;
      o.di = o_dataI; o.dq = o_dataQ; o.s = o_dataSin; o.c = o_dataCos;
      lg.push_back(o);
    end
    i_reset = 0; i_cfg_valid = 0; i_start = 0; i_stop = 0; i_valid = 0;
  endtask

  function automatic int rnd(input real x);
    if (x >= 0.0) return $rtoi(x + 0.5);
    else return -$rtoi(-x + 0.5);
  endfunction

  // Ideal sin/cos at the 6-bit truncated phase, scaled to unity 64 and rounded.
  function automatic void sincos(input logic [15:0] p, output logic [7:0] s, output logic [7:0] c);
    int a;
    real th;
    a = int'(p[15:10]);
    th = 6.283185307179586 * real'(a) / 64.0;
    s = 8'(rnd(64.0 * $sin(th)));
    c = 8'(rnd(64.0 * $cos(th)));
  endfunction

  // Reference: lifecycle as IDLE/RUN/DRAIN with a remaining-cycle count,
  // accepted samples produce a result 2 cycles later and a rotator result 3 later.
  function automatic void build_exp();
    int mode = 0;
    int dl = 0;
    logic [15:0] acc = 0, fr = 0;
    bit acc_ok[$];
    obs_t smp[$];
    obs_t e, sd;
    bit done;
    ex.delete();
    foreach (stim[n]) begin
      e = '0;
      sd = '0;
      acc_ok.push_back(0);
      if (stim[n].rst) begin
        mode = 0; acc = 0; fr = 0;
        e.cfg_ready = 1;
        smp.push_back(sd);
        ex.push_back(e);
        continue;
      end
      if (stim[n].valid && mode == 1) begin
        acc_ok[n] = 1;
        sd.di = stim[n].di; sd.dq = stim[n].dq;
        sincos(acc, sd.s, sd.c);
        acc = acc + fr;
      end
      smp.push_back(sd);
      if (mode == 0 && stim[n].cfg_v) begin
        acc = stim[n].phase; fr = stim[n].freq;
      end
      done = 0;
      if (mode == 0) begin
        if (stim[n].start) mode = 1;
      end else if (mode == 1) begin
        if (stim[n].stop) begin mode = 2; dl = 3; end
      end else begin
        dl--;
        if (dl == 0) begin mode = 0; done = 1; end
      end
      e.busy = (mode != 0); e.ready = (mode == 1); e.cfg_ready = (mode == 0); e.done = done;
      if (n > 0) begin
        e.valid = acc_ok[n-1];
        e.rot = ex[n-1].valid;
        if (e.valid) begin
          e.di = smp[n-1].di; e.dq = smp[n-1].dq; e.s = smp[n-1].s; e.c = smp[n-1].c;
        end else begin
          e.di = ex[n-1].di; e.dq = ex[n-1].dq; e.s = ex[n-1].s; e.c = ex[n-1].c;
        end
      end
      ex.push_back(e);
    end
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("v%b r%b busy%b done%b rdy%b cfgrdy%b I=%h Q=%h sin=%h cos=%h",
                     o.valid, o.rot, o.busy, o.done, o.ready, o.cfg_ready, o.di, o.dq, o.s, o.c);
  endfunction

  task automatic test_reset();
    stim.delete();
    add(1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 16'h0400, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 0, 0, 1, 8'($urandom), 8'($urandom));
    add(1, 0, 0, 0, 0, 0, 1, 8'h11, 8'h22);
    idle(4);
    add(0, 1, 16'h1000, 0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 8'h05, 8'h06);
    add(0, 0, 0, 0, 0, 1, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(5);
    run_stim();
    build_exp();
    foreach (lg[n]) begin
      tests++;
      if (lg[n] !== ex[n]) begin
        failed++;
        $display("FAIL reset cyc%0d got %s need %s", n, fmt(lg[n]), fmt(ex[n]));
      end
    end
    tests++;
    if (lg[5] !== 58'({6'b000001, 32'h0})) begin
      failed++;
      $display("FAIL reset_midrun got %s need all zero, cfg_ready=1", fmt(lg[5]));
    end
    for (int n = 6; n < 10; n++) begin
      tests++;
      if (lg[n].valid !== 1'b0) begin
        failed++;
        $display("FAIL reset_flush cyc%0d got o_valid=%b need 0", n, lg[n].valid);
      end
    end
    for (int n = 13; n < 19; n++) begin
      tests++;
      if (lg[n].done !== 1'b0) begin
        failed++;
        $display("FAIL reset_drain_nodone cyc%0d got o_done=%b need 0", n, lg[n].done);
      end
    end
  endtask

  task automatic test_const();
    stim.delete();
    add(1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 0, 0, 1, 8'd32, 8'd0);
    idle(4);
    run_stim();
    build_exp();
    foreach (lg[n]) begin
      tests++;
      if (lg[n] !== ex[n]) begin
        failed++;
        $display("FAIL const cyc%0d got %s need %s", n, fmt(lg[n]), fmt(ex[n]));
      end
    end
    for (int n = 3; n < 7; n++) begin
      tests++;
      if (lg[n].valid !== 1'b1 || lg[n+1].rot !== 1'b1 || lg[n].s !== 8'd0 ||
          lg[n].c !== 8'd64 || lg[n].di !== 8'd32 || lg[n].dq !== 8'd0) begin
        failed++;
        $display("FAIL const_value cyc%0d got %s need v1 sin=00 cos=40 I=20 Q=00", n, fmt(lg[n]));
      end
    end
  endtask

  task automatic test_ramp();
    int sx[4] = '{0, 6, 12, 19};
    int cx[4] = '{64, 64, 63, 61};
    stim.delete();
    add(1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 16'h0400, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 0, 0, 1, 8'(i), 8'(-i));
    idle(3);
    run_stim();
    build_exp();
    foreach (lg[n]) begin
      tests++;
      if (lg[n] !== ex[n]) begin
        failed++;
        $display("FAIL ramp cyc%0d got %s need %s", n, fmt(lg[n]), fmt(ex[n]));
      end
    end
    for (int j = 0; j < 4; j++) begin
      tests++;
      if (lg[3+j].s !== 8'(sx[j]) || lg[3+j].c !== 8'(cx[j]) || lg[3+j].valid !== 1'b1) begin
        failed++;
        $display("FAIL ramp_value %0d got sin=%0d cos=%0d need sin=%0d cos=%0d",
                 j, $signed(lg[3+j].s), $signed(lg[3+j].c), sx[j], cx[j]);
      end
    end
  endtask

  task automatic test_wrap();
    int sx[5] = '{0, -64, 0, 64, 64};
    int cx[5] = '{64, 0, -64, 0, 0};
    int ix[5] = '{3, 4, 5, 6, 10};
    stim.delete();
    add(1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 16'hC000, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 0, 0, 1, 8'h7f, 8'h80);
    idle(1);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 16'h4000, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 8'h10, 8'h20);
    idle(2);
    run_stim();
    build_exp();
    foreach (lg[n]) begin
      tests++;
      if (lg[n] !== ex[n]) begin
        failed++;
        $display("FAIL wrap cyc%0d got %s need %s", n, fmt(lg[n]), fmt(ex[n]));
      end
    end
    for (int j = 0; j < 5; j++) begin
      tests++;
      if (lg[ix[j]].s !== 8'(sx[j]) || lg[ix[j]].c !== 8'(cx[j])) begin
        failed++;
        $display("FAIL wrap_value %0d got sin=%0d cos=%0d need sin=%0d cos=%0d",
                 j, $signed(lg[ix[j]].s), $signed(lg[ix[j]].c), sx[j], cx[j]);
      end
    end
  endtask

  task automatic test_stop();
    stim.delete();
    add(1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 16'h0400, 0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 8'h01, 8'h02);
    add(0, 0, 0, 0, 0, 0, 1, 8'h03, 8'h04);
    add(0, 0, 0, 0, 0, 1, 1, 8'h05, 8'h06);
    add(0, 1, 16'h2000, 16'h1234, 0, 0, 0, 0, 0);
    idle(4);
    add(0, 0, 0, 0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 8'h07, 8'h08);
    idle(3);
    run_stim();
    build_exp();
    foreach (lg[n]) begin
      tests++;
      if (lg[n] !== ex[n]) begin
        failed++;
        $display("FAIL stop cyc%0d got %s need %s", n, fmt(lg[n]), fmt(ex[n]));
      end
    end
    tests++;
    if (lg[5].valid !== 1'b1 || lg[5].di !== 8'h05) begin
      failed++;
      $display("FAIL stop_last_sample got v=%b I=%h need v=1 I=05", lg[5].valid, lg[5].di);
    end
    for (int n = 4; n < 10; n++) begin
      tests++;
      if (lg[n].done !== (n == 7) || lg[n].busy !== (n < 7)) begin
        failed++;
        $display("FAIL stop_done cyc%0d got done=%b busy=%b need done=%b busy=%b",
                 n, lg[n].done, lg[n].busy, n == 7, n < 7);
      end
    end
    tests++;
    if (lg[12].s !== 8'd19 || lg[12].c !== 8'd61) begin
      failed++;
      $display("FAIL stop_cfg_ignored got sin=%0d cos=%0d need sin=19 cos=61",
               $signed(lg[12].s), $signed(lg[12].c));
    end
  endtask

  task automatic test_cfg_start();
    stim.delete();
    add(1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 16'h0400, 16'h8000, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 8'h40, 8'hc0);
    add(0, 0, 0, 0, 0, 0, 1, 8'h41, 8'hc1);
    idle(3);
    run_stim();
    build_exp();
    foreach (lg[n]) begin
      tests++;
      if (lg[n] !== ex[n]) begin
        failed++;
        $display("FAIL cfg_start cyc%0d got %s need %s", n, fmt(lg[n]), fmt(ex[n]));
      end
    end
    tests++;
    if (lg[3].s !== 8'd0 || lg[3].c !== 8'(-64) || lg[4].s !== 8'(-6) || lg[4].c !== 8'(-64)) begin
      failed++;
      $display("FAIL cfg_start_value got (%0d,%0d),(%0d,%0d) need (0,-64),(-6,-64)",
               $signed(lg[3].s), $signed(lg[3].c), $signed(lg[4].s), $signed(lg[4].c));
    end
  endtask

  task automatic test_random();
    stim.delete();
    add(1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 16'($urandom), 16'($urandom), 1, 0, 0, 0, 0);
    for (int i = 0; i < 300; i++)
      add($urandom_range(0, 59) == 0, $urandom_range(0, 4) == 0, 16'($urandom), 16'($urandom),
          $urandom_range(0, 5) == 0, $urandom_range(0, 24) == 0, $urandom_range(0, 9) < 7,
          8'($urandom), 8'($urandom));
    idle(5);
    run_stim();
    build_exp();
    foreach (lg[n]) begin
      tests++;
      if (lg[n] !== ex[n]) begin
        failed++;
        $display("FAIL random cyc%0d got %s need %s", n, fmt(lg[n]), fmt(ex[n]));
      end
    end
  endtask

  initial begin
    test_reset();
    test_const();
    test_ramp();
    test_wrap();
    test_stop();
    test_cfg_start();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
